audio_sample_packer_writer: RTL and testbench
=============================================

Name: audio_sample_packer_writer

Overview:
- Upstream feeder for the 4096x32 single-port on-chip sample RAM.
- Accepts a 16-bit audio sample stream with valid/ready and packs sample pairs into 32-bit words.
- Writes each word into a configurable address window through the RAM's chipselect/write/byteenable port.
- Signals frame completion to the identifier control logic.

Parameters:
- MEM_AW, 12, RAM word-address width; address arithmetic wraps modulo 2^MEM_AW.
- SAMPLE_W, 16, input sample width; word width is 2*SAMPLE_W.
- CONTINUOUS, 0: 0 = one-shot frame; 1 = ring mode, rewinds to base after each frame.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- cfg_start  in  1  pulse: latch config and begin capture (ignored unless IDLE).
- cfg_stop  in  1  pulse: end capture early (ignored unless CAPTURE).
- cfg_base  in  MEM_AW  first word address of window.
- cfg_len_m1  in  MEM_AW  frame length in words minus 1 (0 → 1 word, 4095 → 4096 words).
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- s_data  in  SAMPLE_W  audio sample.
- s_last  in  1  final sample of stream, qualified by acceptance.
- mem_address  out  MEM_AW  RAM word address.
- mem_byteenable  out  4  RAM byte enables.
- mem_chipselect  out  1  equals mem_write.
- mem_write  out  1  one-cycle write strobe.
- mem_writedata  out  32  packed word.
- mem_clken  out  1  RAM clock enable; constant 1.
- busy  out  1  high in CAPTURE and DONE.
- done  out  1  one-cycle pulse at end of capture.
- frame_done  out  1  one-cycle pulse with the write of the last word of each frame.
- words_written  out  MEM_AW+1  words written since cfg_start; saturates at 2^MEM_AW in ring mode.

Behaviour:
- **Reset (reset_n=0 at edge):** state IDLE. s_ready, mem_write, mem_chipselect, busy, done, frame_done = 0. mem_address, mem_writedata, words_written = 0. mem_byteenable = 4'b0000. Pending half-word discarded. No write in the cycle after reset release.
- **States:** IDLE, CAPTURE, DONE.
- **IDLE:**
  - s_ready=0.
  - On cfg_start: latch base and len, clear word counter, half flag and words_written, go to CAPTURE.
- **CAPTURE:** s_ready=1 combinationally. Earlier sample occupies bits [15:0].
  - Accepted sample with half flag clear: store it as the low half and set the flag.
  - Accepted sample with half flag set: register a write for the next cycle — writedata {s_data, low}, byteenable 1111, address = base + word_idx (mod 2^MEM_AW). Clear flag, word_idx++, words_written++.
- **Registered write outputs:** mem_write/mem_chipselect are high exactly one cycle after the accepting edge. Latency from the second sample's acceptance to the write strobe is 1 cycle. At most one write per 2 accepted samples, so there is no backpressure from the RAM.
- **Frame end** (write of word_idx == len_m1):
  - frame_done pulses with that write.
  - CONTINUOUS=0: next state DONE.
  - CONTINUOUS=1: word_idx←0, remain in CAPTURE.
- **s_last:**
  - On a high-half sample: normal full write, go to DONE.
  - On a low-half sample: write {16'h0000, s_data} with byteenable 0011, go to DONE.
  - This word counts in words_written. frame_done pulses only if it is the frame's last word.
- **cfg_stop in CAPTURE with no acceptance that cycle:**
  - Half flag set: partial write of the pending low half (byteenable 0011), go to DONE.
  - Half flag clear: go to DONE with no write.
- **cfg_stop in the same cycle as an acceptance:** the sample is processed first, including packing. If this leaves a pending low half, it is flushed as a partial word. State goes to DONE.
- **DONE:** lasts one cycle; s_ready=0, done=1, busy=1. Any final write strobe coincides with this cycle. Next state IDLE.
- **Priority:** s_last and frame end both force DONE and are not double-counted. cfg_start in CAPTURE or DONE is ignored.
- **Address wrap:** base + idx wraps modulo 4096, e.g. base 4094 with 4 words writes 4094, 4095, 0, 1.
- **Reset mid-operation:** immediate return to IDLE per the reset values; the RAM contents already written are untouched.

Test Plan:
1. base=0x010, len_m1=1; samples 0x1111, 0x2222, 0x3333, 0x4444 back-to-back → writes 0x22221111@0x010 and 0x44443333@0x011, both BE=1111. frame_done and done pulse with the second write; s_ready drops the following cycle; words_written=2.
2. base=0xFFE, len_m1=3; 8 samples → addresses 0xFFE, 0xFFF, 0x000, 0x001 in order. done pulses once.
3. len_m1=9; 3 samples, third with s_last=1 (0xABCD) → second write 0x0000ABCD with BE=0011, done=1, frame_done=0, words_written=2.
4. 1 sample 0x5A5A, then cfg_stop with s_valid=0 → a single write 0x00005A5A with BE=0011 the next cycle, plus done. A later cfg_start with s_valid low produces no write.
5. CONTINUOUS=1, base=0x100, len_m1=1; 10 samples → writes at 0x100, 0x101, 0x100, 0x101, 0x100 and frame_done pulses after the 2nd and 4th writes; cfg_stop → done, no write.
6. reset_n=0 for 1 cycle after one pending sample → no write ever emitted for it. All outputs read 0 except mem_clken=1; a subsequent cfg_start restarts cleanly at cfg_base.

Source files
------------

// File: rtl/audio_sample_packer_writer.sv
// Packs pairs of audio samples into RAM words and writes them into a wrapping
// address window; one-shot or ring capture, with early stop and partial flush.
module audio_sample_packer_writer #(
    parameter int MEM_AW     = 12,
    parameter int SAMPLE_W   = 16,
    parameter int CONTINUOUS = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [MEM_AW-1:0]     cfg_base,
    input  logic [MEM_AW-1:0]     cfg_len_m1,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [SAMPLE_W-1:0]   s_data,
    input  logic                  s_last,
    output logic [MEM_AW-1:0]     mem_address,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [2*SAMPLE_W-1:0] mem_writedata,
    output logic                  mem_clken,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_done,
    output logic [MEM_AW:0]       words_written,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [MEM_AW:0] WW_MAX = {1'b1, {MEM_AW{1'b0}}};

    state_t                state;
    logic [MEM_AW-1:0]     base_r;
    logic [MEM_AW-1:0]     len_r;
    logic [MEM_AW-1:0]     word_idx;
    logic                  half;
    logic [SAMPLE_W-1:0]   low_r;

    logic                  accept;
    logic                  wr_fire;
    logic                  wr_full;
    logic                  keep_low;
    logic                  go_done;
    logic                  frame_end;
    logic [SAMPLE_W-1:0]   wr_low;

    // Handshake: a sample transfers on a rising edge where s_valid & s_ready;
    // s_ready is high for the whole CAPTURE state and never depends on s_valid.
    assign s_ready        = (state == CAPTURE);
    assign accept         = s_valid & s_ready;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign mem_clken      = 1'b1;
    assign mem_chipselect = mem_write;
    assign dbg_state      = state;

    always_comb begin
        wr_fire  = 1'b0;
        wr_full  = 1'b0;
        keep_low = 1'b0;
        go_done  = 1'b0;
        if (state == CAPTURE) begin
            if (accept) begin
                if (half) begin
                    wr_fire = 1'b1;
                    wr_full = 1'b1;
                end else if (s_last || cfg_stop) begin
                    wr_fire = 1'b1;
                end else begin
                    keep_low = 1'b1;
                end
                if (s_last || cfg_stop) go_done = 1'b1;
            end else if (cfg_stop) begin
                // Flush a pending low half as a partial word on early stop.
                go_done = 1'b1;
                wr_fire = half;
            end
        end
        frame_end = wr_fire && (word_idx == len_r);
        if (frame_end && (CONTINUOUS == 0)) go_done = 1'b1;
        wr_low = accept ? s_data : low_r;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            base_r         <= '0;
            len_r          <= '0;
            word_idx       <= '0;
            half           <= 1'b0;
            low_r          <= '0;
            mem_write      <= 1'b0;
            frame_done     <= 1'b0;
            mem_address    <= '0;
            mem_writedata  <= '0;
            mem_byteenable <= 4'b0000;
            words_written  <= '0;
        end else begin
            mem_write  <= wr_fire;
            frame_done <= frame_end;
            if (wr_fire) begin
                mem_address    <= base_r + word_idx;
                mem_writedata  <= wr_full ? {s_data, low_r} : {{SAMPLE_W{1'b0}}, wr_low};
                mem_byteenable <= wr_full ? 4'b1111 : 4'b0011;
                half           <= 1'b0;
                word_idx       <= frame_end ? '0 : word_idx + MEM_AW'(1);
                if (words_written != WW_MAX) words_written <= words_written + (MEM_AW+1)'(1);
            end else if (keep_low) begin
                low_r <= s_data;
                half  <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        base_r        <= cfg_base;
                        len_r         <= cfg_len_m1;
                        word_idx      <= '0;
                        half          <= 1'b0;
                        words_written <= '0;
                        state         <= CAPTURE;
                    end
                end
                CAPTURE: if (go_done) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_sample_packer_writer.sv
// Directed bench for audio_sample_packer_writer: one-shot instance plus a
// ring-mode instance sharing stimulus; writes are logged and checked per test.
module tb_audio_sample_packer_writer;

    localparam int AW = 12;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_stop = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [AW-1:0] cfg_len_m1 = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic [SW-1:0] s_data = '0;

    logic          s_ready, mem_chipselect, mem_write, mem_clken, busy, done, frame_done;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_writedata;
    logic [AW:0]   words_written;
    logic [1:0]    dbg_state;

    logic          r_s_ready, r_mem_chipselect, r_mem_write, r_mem_clken, r_busy, r_done, r_frame_done;
    logic [AW-1:0] r_mem_address;
    logic [3:0]    r_mem_byteenable;
    logic [31:0]   r_mem_writedata;
    logic [AW:0]   r_words_written;
    logic [1:0]    r_dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    audio_sample_packer_writer #(.MEM_AW(AW), .SAMPLE_W(SW), .CONTINUOUS(0)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_base(cfg_base), .cfg_len_m1(cfg_len_m1), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .mem_address(mem_address),
        .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .busy(busy), .done(done), .frame_done(frame_done),
        .words_written(words_written), .dbg_state(dbg_state)
    );

    audio_sample_packer_writer #(.MEM_AW(AW), .SAMPLE_W(SW), .CONTINUOUS(1)) dut_ring (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_base(cfg_base), .cfg_len_m1(cfg_len_m1), .s_valid(s_valid), .s_ready(r_s_ready),
        .s_data(s_data), .s_last(s_last), .mem_address(r_mem_address),
        .mem_byteenable(r_mem_byteenable), .mem_chipselect(r_mem_chipselect),
        .mem_write(r_mem_write), .mem_writedata(r_mem_writedata), .mem_clken(r_mem_clken),
        .busy(r_busy), .done(r_done), .frame_done(r_frame_done),
        .words_written(r_words_written), .dbg_state(r_dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Write log: one entry per write strobe, with frame_done/done seen in that cycle
    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
        logic          fd;
        logic          dn;
    } wr_t;

    wr_t wr_q[$];
    wr_t r_wr_q[$];
    wr_t mon_w, r_mon_w;
    int done_cnt = 0, fd_cnt = 0, r_done_cnt = 0, r_fd_cnt = 0;
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (mem_write) begin
            mon_w.a = mem_address; mon_w.d = mem_writedata; mon_w.be = mem_byteenable;
            mon_w.fd = frame_done; mon_w.dn = done;
            wr_q.push_back(mon_w);
        end
        if (r_mem_write) begin
            r_mon_w.a = r_mem_address; r_mon_w.d = r_mem_writedata; r_mon_w.be = r_mem_byteenable;
            r_mon_w.fd = r_frame_done; r_mon_w.dn = r_done;
            r_wr_q.push_back(r_mon_w);
        end
        if (done) done_cnt++;
        if (frame_done) fd_cnt++;
        if (r_done) r_done_cnt++;
        if (r_frame_done) r_fd_cnt++;
    end

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        wr_q.delete(); r_wr_q.delete(); exp_q.delete();
        done_cnt = 0; fd_cnt = 0; r_done_cnt = 0; r_fd_cnt = 0;
    endtask

    task automatic start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        cfg_base = b; cfg_len_m1 = l; cfg_start = 1'b1;
        cyc(1);
        cfg_start = 1'b0;
    endtask

    task automatic send(input logic [SW-1:0] d, input logic last, input logic stop);
        s_valid = 1'b1; s_data = d; s_last = last; cfg_stop = stop;
        cyc(1);
        s_valid = 1'b0; s_last = 1'b0; cfg_stop = 1'b0;
    endtask

    task automatic pulse_stop();
        cfg_stop = 1'b1;
        cyc(1);
        cfg_stop = 1'b0;
    endtask

    function automatic wr_t mk(input logic [AW-1:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic fd, input logic dn);
        wr_t w;
        w.a = a; w.d = d; w.be = be; w.fd = fd; w.dn = dn;
        return w;
    endfunction

    // Tests
    task automatic test_reset();
        reset_n = 1'b0;
        cyc(3);
        n_cmp++;
        if ({s_ready, mem_write, mem_chipselect, busy, done, frame_done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {s_ready, mem_write, mem_chipselect, busy, done, frame_done});
        end
        n_cmp++;
        if ({mem_address, mem_writedata, mem_byteenable} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got a=%h d=%h be=%b want 0", mem_address, mem_writedata, mem_byteenable);
        end
        n_cmp++;
        if (words_written !== '0) begin
            n_fail++; $display("FAIL reset_ww: got %0d want 0", words_written);
        end
        n_cmp++;
        if (mem_clken !== 1'b1) begin
            n_fail++; $display("FAIL reset_clken: got %b want 1", mem_clken);
        end
        reset_n = 1'b1;
        cyc(1);
        n_cmp++;
        if ({mem_write, dbg_state} !== 3'b000) begin
            n_fail++; $display("FAIL reset_release: got wr=%b st=%0d want 0/0", mem_write, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        wr_t e[2];
        clear_mon();
        e[0] = mk(12'h010, 32'h22221111, 4'b1111, 1'b0, 1'b0);
        e[1] = mk(12'h011, 32'h44443333, 4'b1111, 1'b1, 1'b1);
        start(12'h010, 12'd1);
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready_capture: got %b want 1", s_ready);
        end
        send(16'h1111, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b0);
        send(16'h4444, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({mem_write, frame_done, done, busy, s_ready} !== 5'b11110) begin
            n_fail++;
            $display("FAIL b2b_last_cycle: got wr/fd/dn/busy/rdy=%b want 11110",
                     {mem_write, frame_done, done, busy, s_ready});
        end
        n_cmp++;
        if (words_written !== 13'd2) begin
            n_fail++; $display("FAIL b2b_ww: got %0d want 2", words_written);
        end
        cyc(3);
        n_cmp++;
        if ({busy, done, dbg_state} !== 4'b0000) begin
            n_fail++; $display("FAIL b2b_idle: got busy=%b done=%b st=%0d want 0/0/0", busy, done, dbg_state);
        end
        n_cmp++;
        if (wr_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_nwrites: got %0d want 2", wr_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (i < wr_q.size()) begin
                n_cmp++;
                if (wr_q[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL b2b_write%0d: got a=%h d=%h be=%b fd=%b dn=%b want a=%h d=%h be=%b fd=%b dn=%b",
                             i, wr_q[i].a, wr_q[i].d, wr_q[i].be, wr_q[i].fd, wr_q[i].dn,
                             e[i].a, e[i].d, e[i].be, e[i].fd, e[i].dn);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a[4];
        clear_mon();
        exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
        exp_q.push_back(32'h10011000); exp_q.push_back(32'h10031002);
        exp_q.push_back(32'h10051004); exp_q.push_back(32'h10071006);
        start(12'hFFE, 12'd3);
        for (int k = 0; k < 8; k++) send(16'h1000 + 16'(k), 1'b0, 1'b0);
        cyc(3);
        n_cmp++;
        if (wr_q.size() != 4) begin
            n_fail++; $display("FAIL wrap_nwrites: got %0d want 4", wr_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            if (i < wr_q.size()) begin
                n_cmp++;
                if (wr_q[i].a !== exp_a[i] || wr_q[i].d !== exp_q[i] || wr_q[i].be !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL wrap_write%0d: got a=%h d=%h be=%b want a=%h d=%h be=1111",
                             i, wr_q[i].a, wr_q[i].d, wr_q[i].be, exp_a[i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (done_cnt != 1 || fd_cnt != 1) begin
            n_fail++; $display("FAIL wrap_pulses: got done=%0d fd=%0d want 1/1", done_cnt, fd_cnt);
        end
        n_cmp++;
        if (words_written !== 13'd4) begin
            n_fail++; $display("FAIL wrap_ww: got %0d want 4", words_written);
        end
    endtask

    task automatic test_last();
        wr_t e[3];
        clear_mon();
        e[0] = mk(12'h200, 32'h00020001, 4'b1111, 1'b0, 1'b0);
        e[1] = mk(12'h201, 32'h0000ABCD, 4'b0011, 1'b0, 1'b1);
        e[2] = mk(12'h500, 32'hB2B2A1A1, 4'b1111, 1'b0, 1'b1);
        start(12'h200, 12'd9);
        send(16'h0001, 1'b0, 1'b0);
        send(16'h0002, 1'b0, 1'b0);
        send(16'hABCD, 1'b1, 1'b0);
        cyc(3);
        n_cmp++;
        if (words_written !== 13'd2) begin
            n_fail++; $display("FAIL last_low_ww: got %0d want 2", words_written);
        end
        start(12'h500, 12'd9);
        send(16'hA1A1, 1'b0, 1'b0);
        send(16'hB2B2, 1'b1, 1'b0);
        cyc(3);
        n_cmp++;
        if (words_written !== 13'd1) begin
            n_fail++; $display("FAIL last_high_ww: got %0d want 1", words_written);
        end
        n_cmp++;
        if (wr_q.size() != 3 || done_cnt != 2 || fd_cnt != 0) begin
            n_fail++;
            $display("FAIL last_counts: got writes=%0d done=%0d fd=%0d want 3/2/0", wr_q.size(), done_cnt, fd_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < wr_q.size()) begin
                n_cmp++;
                if (wr_q[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL last_write%0d: got a=%h d=%h be=%b fd=%b dn=%b want a=%h d=%h be=%b fd=%b dn=%b",
                             i, wr_q[i].a, wr_q[i].d, wr_q[i].be, wr_q[i].fd, wr_q[i].dn,
                             e[i].a, e[i].d, e[i].be, e[i].fd, e[i].dn);
                end
            end
        end
    endtask

    task automatic test_stop();
        wr_t e[3];
        clear_mon();
        e[0] = mk(12'h300, 32'h00005A5A, 4'b0011, 1'b0, 1'b1);
        e[1] = mk(12'h400, 32'h22221111, 4'b1111, 1'b0, 1'b0);
        e[2] = mk(12'h401, 32'h00003333, 4'b0011, 1'b0, 1'b1);
        start(12'h300, 12'd5);
        send(16'h5A5A, 1'b0, 1'b0);
        pulse_stop();
        cyc(2);
        start(12'h310, 12'd5);
        cyc(5);
        n_cmp++;
        if ({dbg_state, s_ready, wr_q.size() == 1} !== 4'b0111) begin
            n_fail++;
            $display("FAIL stop_restart_idle: got st=%0d rdy=%b writes=%0d want 1/1/1", dbg_state, s_ready, wr_q.size());
        end
        pulse_stop();
        cyc(3);
        n_cmp++;
        if (wr_q.size() != 1 || done_cnt != 2 || words_written !== 13'd0) begin
            n_fail++;
            $display("FAIL stop_empty: got writes=%0d done=%0d ww=%0d want 1/2/0", wr_q.size(), done_cnt, words_written);
        end
        start(12'h400, 12'd9);
        send(16'h1111, 1'b0, 1'b0);
        send(16'h2222, 1'b0, 1'b0);
        send(16'h3333, 1'b0, 1'b1);
        cyc(3);
        n_cmp++;
        if (wr_q.size() != 3 || words_written !== 13'd2) begin
            n_fail++; $display("FAIL stop_accept_counts: got writes=%0d ww=%0d want 3/2", wr_q.size(), words_written);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < wr_q.size()) begin
                n_cmp++;
                if (wr_q[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL stop_write%0d: got a=%h d=%h be=%b fd=%b dn=%b want a=%h d=%h be=%b fd=%b dn=%b",
                             i, wr_q[i].a, wr_q[i].d, wr_q[i].be, wr_q[i].fd, wr_q[i].dn,
                             e[i].a, e[i].d, e[i].be, e[i].fd, e[i].dn);
                end
            end
        end
    endtask

    task automatic test_ring();
        wr_t e[5];
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        clear_mon();
        e[0] = mk(12'h100, 32'h20012000, 4'b1111, 1'b0, 1'b0);
        e[1] = mk(12'h101, 32'h20032002, 4'b1111, 1'b1, 1'b0);
        e[2] = mk(12'h100, 32'h20052004, 4'b1111, 1'b0, 1'b0);
        e[3] = mk(12'h101, 32'h20072006, 4'b1111, 1'b1, 1'b0);
        e[4] = mk(12'h100, 32'h20092008, 4'b1111, 1'b0, 1'b0);
        start(12'h100, 12'd1);
        for (int k = 0; k < 10; k++) send(16'h2000 + 16'(k), 1'b0, 1'b0);
        cyc(2);
        n_cmp++;
        if ({r_dbg_state, r_busy} !== 3'b011) begin
            n_fail++; $display("FAIL ring_still_capture: got st=%0d busy=%b want 1/1", r_dbg_state, r_busy);
        end
        pulse_stop();
        cyc(3);
        n_cmp++;
        if (r_wr_q.size() != 5 || r_done_cnt != 1 || r_fd_cnt != 2 || r_words_written !== 13'd5) begin
            n_fail++;
            $display("FAIL ring_counts: got writes=%0d done=%0d fd=%0d ww=%0d want 5/1/2/5",
                     r_wr_q.size(), r_done_cnt, r_fd_cnt, r_words_written);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < r_wr_q.size()) begin
                n_cmp++;
                if (r_wr_q[i] !== e[i]) begin
                    n_fail++;
                    $display("FAIL ring_write%0d: got a=%h d=%h be=%b fd=%b dn=%b want a=%h d=%h be=%b fd=%b dn=%b",
                             i, r_wr_q[i].a, r_wr_q[i].d, r_wr_q[i].be, r_wr_q[i].fd, r_wr_q[i].dn,
                             e[i].a, e[i].d, e[i].be, e[i].fd, e[i].dn);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        wr_t e0;
        clear_mon();
        e0 = mk(12'h060, 32'h56781234, 4'b1111, 1'b1, 1'b1);
        start(12'h050, 12'd3);
        send(16'h7777, 1'b0, 1'b0);
        reset_n = 1'b0;
        cyc(1);
        n_cmp++;
        if ({s_ready, mem_write, mem_chipselect, busy, done, frame_done, mem_byteenable} !== 10'b0 ||
            mem_address !== '0 || mem_writedata !== '0 || words_written !== '0 || mem_clken !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rdy=%b wr=%b cs=%b busy=%b dn=%b fd=%b be=%b a=%h d=%h ww=%0d ck=%b want all 0, clken 1",
                     s_ready, mem_write, mem_chipselect, busy, done, frame_done, mem_byteenable,
                     mem_address, mem_writedata, words_written, mem_clken);
        end
        reset_n = 1'b1;
        cyc(4);
        n_cmp++;
        if (wr_q.size() != 0) begin
            n_fail++; $display("FAIL midreset_nowrite: got %0d writes want 0", wr_q.size());
        end
        start(12'h060, 12'd0);
        send(16'h1234, 1'b0, 1'b0);
        send(16'h5678, 1'b0, 1'b0);
        cyc(3);
        n_cmp++;
        if (wr_q.size() != 1 || words_written !== 13'd1) begin
            n_fail++; $display("FAIL midreset_restart: got writes=%0d ww=%0d want 1/1", wr_q.size(), words_written);
        end
        if (wr_q.size() > 0) begin
            n_cmp++;
            if (wr_q[0] !== e0) begin
                n_fail++;
                $display("FAIL midreset_write: got a=%h d=%h be=%b fd=%b dn=%b want a=%h d=%h be=%b fd=%b dn=%b",
                         wr_q[0].a, wr_q[0].d, wr_q[0].be, wr_q[0].fd, wr_q[0].dn,
                         e0.a, e0.d, e0.be, e0.fd, e0.dn);
            end
        end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_last();
        test_stop();
        test_ring();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
